if_prefetch_stage: RTL and testbench

//  Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue and a

---
 rtl/if_prefetch_stage.sv | 117 +++++++++++
 tb/tb_if_prefetch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: drives a 1-cycle synchronous ROM and buffers PC-tagged
// instructions in a DEPTH-entry queue toward decode. `IF_FLUSH_CNT_EN adds flush_count.
module if_prefetch_stage #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
`ifdef IF_FLUSH_CNT_EN
  ,
  output logic [15:0]        flush_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic               r_inflight;
  logic [INSTR_W-1:0] r_q_instr [DEPTH];
  logic [ADDR_W-1:0]  r_q_pc    [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [CNT_W:0]     w_credit;

  // Occupied slots plus the response still on its way back; never exceeds DEPTH.
  assign w_credit  = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
  assign imem_req  = reset_n && !branch_taken && (w_credit < (CNT_W+1)'(DEPTH));
  assign imem_addr = r_fetch_pc;
  assign out_valid = (r_count != '0) && !branch_taken;
  assign w_push    = r_inflight && !branch_taken;
  assign w_pop     = out_valid && out_ready;
  assign out_instr = r_q_instr[r_head];
  assign out_pc    = r_q_pc[r_head];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc    <= ADDR_W'(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      // imem_req is low during a flush, so the next-cycle response is dropped too.
      r_inflight <= imem_req;
      if (imem_req)
        r_inflight_pc <= r_fetch_pc;
      if (branch_taken)
        r_fetch_pc <= branch_address;
      else if (imem_req)
        r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (branch_taken) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + PTR_W'(1);
      if (w_pop)
        r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_q_instr[r_tail] <= imem_rdata;
      r_q_pc[r_tail]    <= r_inflight_pc;
    end
  end

`ifdef IF_FLUSH_CNT_EN
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_flush_cnt <= '0;
    else if (branch_taken && (r_flush_cnt != '1))
      r_flush_cnt <= r_flush_cnt + 16'd1;
  end

  assign flush_count = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: a 32-bit instance and an 8-bit-address
// instance starting at 0xFC, each fed by a behavioural 1-cycle ROM.
module tb_if_prefetch_stage;

  logic        clock;
  logic        reset_n;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        imem_req8;
  logic [7:0]  imem_addr8;
  logic [31:0] imem_rdata8;
  logic        out_valid8;
  logic [31:0] out_instr8;
  logic [7:0]  out_pc8;
`ifdef IF_FLUSH_CNT_EN
  logic [15:0] flush_count;
  logic [15:0] flush_count8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_prefetch_stage #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(0), .PC_STEP(4)) u_dut (
    .clock(clock), .reset_n(reset_n), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
`ifdef IF_FLUSH_CNT_EN
    , .flush_count(flush_count)
`endif
  );

  if_prefetch_stage #(.ADDR_W(8), .INSTR_W(32), .DEPTH(4), .RESET_PC(252), .PC_STEP(4)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .branch_taken(1'b0),
    .branch_address(8'h00), .imem_req(imem_req8), .imem_addr(imem_addr8),
    .imem_rdata(imem_rdata8), .out_valid(out_valid8), .out_ready(1'b1),
    .out_instr(out_instr8), .out_pc(out_pc8)
`ifdef IF_FLUSH_CNT_EN
    , .flush_count(flush_count8)
`endif
  );

  function automatic logic [31:0] rom(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always_ff @(posedge clock) begin
    imem_rdata  <= rom(imem_addr);
    imem_rdata8 <= rom({24'h0, imem_addr8});
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", out_instr); end
    n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", out_pc); end
    n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL reset_valid8 got %b want 0", out_valid8); end
`ifdef IF_FLUSH_CNT_EN
    n_cmp++; if (flush_count !== 16'h0) begin n_err++; $display("FAIL reset_flush got %h want 0", flush_count); end
`endif
  endtask

  task automatic test_stream();
    next_cycle();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      @(negedge clock);
      if (c == 0) begin
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h0})
          begin n_err++; $display("FAIL first_req got %b/%h want 1/0", imem_req, imem_addr); end
      end
      if (c < 2) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL early_valid c=%0d got %b want 0", c, out_valid); end
      end else begin
        n_cmp++; if ({out_valid, out_pc} !== {1'b1, 32'(4 * (c - 2))})
          begin n_err++; $display("FAIL stream_pc c=%0d got %b/%h want 1/%h", c, out_valid, out_pc, 4 * (c - 2)); end
        n_cmp++; if (out_instr !== rom(32'(4 * (c - 2))))
          begin n_err++; $display("FAIL stream_instr c=%0d got %h want %h", c, out_instr, rom(32'(4 * (c - 2)))); end
      end
    end
  endtask

  task automatic test_stall();
    for (int c = 10; c < 30; c++) begin
      next_cycle();
      out_ready = (c >= 20);
      @(negedge clock);
      if (c < 20) begin
        n_cmp++; if ({out_valid, out_pc, out_instr} !== {1'b1, 32'd32, rom(32'd32)})
          begin n_err++; $display("FAIL stall_head c=%0d got %b/%h want 1/20", c, out_valid, out_pc); end
        if (c >= 12) begin
          n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req c=%0d got %b want 0", c, imem_req); end
        end
        if (c == 19) begin
          n_cmp++; if (imem_addr !== 32'd48) begin n_err++; $display("FAIL stall_fetch_pc got %h want 30", imem_addr); end
        end
      end else begin
        n_cmp++; if ({out_valid, out_pc} !== {1'b1, 32'(32 + 4 * (c - 20))})
          begin n_err++; $display("FAIL resume_pc c=%0d got %b/%h want 1/%h", c, out_valid, out_pc, 32 + 4 * (c - 20)); end
        if (c == 20) begin
          n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL resume_req got %b want 0", imem_req); end
        end
      end
    end
  endtask

  task automatic test_branch();
    next_cycle();
    out_ready = 1'b0;
    @(negedge clock);
    n_cmp++; if ({out_valid, out_pc} !== {1'b1, 32'd72})
      begin n_err++; $display("FAIL pre_branch got %b/%h want 1/48", out_valid, out_pc); end
    next_cycle();
    out_ready = 1'b1; branch_taken = 1'b1; branch_address = 32'h100;
    @(negedge clock);
    n_cmp++; if ({out_valid, imem_req} !== 2'b00)
      begin n_err++; $display("FAIL branch_cycle got valid/req %b/%b want 0/0", out_valid, imem_req); end
    next_cycle();
    branch_taken = 1'b0;
    @(negedge clock);
    n_cmp++; if ({out_valid, imem_req, imem_addr} !== {2'b01, 32'h100})
      begin n_err++; $display("FAIL branch_req got %b/%b/%h want 0/1/100", out_valid, imem_req, imem_addr); end
    next_cycle();
    @(negedge clock);
    n_cmp++; if ({out_valid, imem_addr} !== {1'b0, 32'h104})
      begin n_err++; $display("FAIL branch_gap got %b/%h want 0/104", out_valid, imem_addr); end
    next_cycle();
    @(negedge clock);
    n_cmp++; if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h100, rom(32'h100)})
      begin n_err++; $display("FAIL branch_target got %b/%h/%h want 1/100/%h", out_valid, out_pc, out_instr, rom(32'h100)); end
    next_cycle();
    @(negedge clock);
    n_cmp++; if ({out_valid, out_pc} !== {1'b1, 32'h104})
      begin n_err++; $display("FAIL branch_next got %b/%h want 1/104", out_valid, out_pc); end
  endtask

  task automatic test_back_to_back_branch();
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      branch_taken   = (k < 2);
      branch_address = (k == 0) ? 32'h200 : 32'h300;
      @(negedge clock);
      n_cmp++; if (out_valid && (out_pc >= 32'h200) && (out_pc < 32'h300))
        begin n_err++; $display("FAIL stale_target k=%0d got %h want none in 200..2ff", k, out_pc); end
      if (k < 4) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid k=%0d got %b want 0", k, out_valid); end
      end
      if (k == 2) begin
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h300})
          begin n_err++; $display("FAIL b2b_req got %b/%h want 1/300", imem_req, imem_addr); end
      end
      if (k == 4 || k == 5) begin
        n_cmp++; if ({out_valid, out_pc} !== {1'b1, 32'(32'h300 + 4 * (k - 4))})
          begin n_err++; $display("FAIL b2b_pc k=%0d got %b/%h want 1/%h", k, out_valid, out_pc, 32'h300 + 4 * (k - 4)); end
      end
`ifdef IF_FLUSH_CNT_EN
      if (k == 5) begin
        n_cmp++; if (flush_count !== 16'd3) begin n_err++; $display("FAIL flush_count got %0d want 3", flush_count); end
      end
`endif
    end
  endtask

  task automatic test_addr_wrap();
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle();
      @(negedge clock);
      if (c == 0) begin
        n_cmp++; if ({imem_req8, imem_addr8} !== {1'b1, 8'hFC})
          begin n_err++; $display("FAIL wrap_req got %b/%h want 1/fc", imem_req8, imem_addr8); end
      end
      if (c >= 2) begin
        n_cmp++; if ({out_valid8, out_pc8} !== {1'b1, 8'(8'hFC + 4 * (c - 2))})
          begin n_err++; $display("FAIL wrap_pc c=%0d got %b/%h want 1/%h", c, out_valid8, out_pc8, 8'(8'hFC + 4 * (c - 2))); end
        n_cmp++; if (out_instr8 !== rom({24'h0, 8'(8'hFC + 4 * (c - 2))}))
          begin n_err++; $display("FAIL wrap_instr c=%0d got %h", c, out_instr8); end
      end
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({imem_req, out_valid, out_pc, out_instr} !== {2'b00, 32'h0, 32'h0})
      begin n_err++; $display("FAIL midreset_out got %b/%b/%h/%h want 0/0/0/0", imem_req, out_valid, out_pc, out_instr); end
`ifdef IF_FLUSH_CNT_EN
    n_cmp++; if (flush_count !== 16'h0) begin n_err++; $display("FAIL midreset_flush got %h want 0", flush_count); end
`endif
    next_cycle();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cycle();
      @(negedge clock);
      if (c >= 2) begin
        n_cmp++; if ({out_valid, out_pc} !== {1'b1, 32'(4 * (c - 2))})
          begin n_err++; $display("FAIL midreset_pc c=%0d got %b/%h want 1/%h", c, out_valid, out_pc, 4 * (c - 2)); end
      end
    end
  endtask

  initial begin
    reset_n        = 1'b1;
    branch_taken   = 1'b0;
    branch_address = 32'h0;
    out_ready      = 1'b0;
    #2 reset_n = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_back_to_back_branch();
    test_addr_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
